hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock, rising-edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: IF_ID_Rs, IF_ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports: ID_UsesRt  in  1  ID instruction reads Rt. ID_Branch  in  1  ID instruction is a branch.
REQ-005 SHALL have ports: BranchTaken, ID_Jump  in  1 each  redirect resolved in ID.
REQ-006 SHALL have ports: ID_EX_WriteReg  in  5. ID_EX_RegWrite, ID_EX_MemRead  in  1 each  EX-stage producer.
REQ-007 SHALL have ports: EX_MEM_WriteReg  in  5. EX_MEM_MemRead  in  1  MEM-stage load.
REQ-008 SHALL have ports: PCWrite, IF_ID_Write  out  1 each  1 = advance. ID_EX_Flush, IF_ID_Flush  out  1 each  1 = insert bubble.
REQ-009 SHALL have port StallCount  out  32  stall-cycle counter (see Configuration).

Function
REQ-010 Match(r) SHALL mean r != 0 and (r == IF_ID_Rs or (ID_UsesRt and r == IF_ID_Rt)).
REQ-011 need SHALL be the maximum of the following, 0 if none applies.
REQ-012 need term: 1 for load-use, ID_EX_MemRead and Match(ID_EX_WriteReg).
REQ-013 need term: 1 for branch on ALU result, ID_Branch and ID_EX_RegWrite and not ID_EX_MemRead and Match(ID_EX_WriteReg).
REQ-014 need term: 2 for branch on load in EX, ID_Branch and ID_EX_MemRead and Match(ID_EX_WriteReg).
REQ-015 need term: 1 for branch on load in MEM, ID_Branch and EX_MEM_MemRead and Match(EX_MEM_WriteReg).
REQ-016 FSM SHALL have states RUN and HOLD, plus a 2-bit counter cnt.
REQ-017 stall SHALL be 1 when state is HOLD, or when state is RUN and need > 0.
REQ-018 When stall = 1: PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1, same cycle (combinational).
REQ-019 When stall = 0: PCWrite = 1, IF_ID_Write = 1, ID_EX_Flush = 0.
REQ-020 RUN with need = 2 SHALL load cnt = 1 and go to HOLD; RUN with need <= 1 SHALL stay in RUN.
REQ-021 HOLD SHALL stall unconditionally, ignoring hazard inputs; it SHALL decrement cnt and return to RUN when cnt reaches 0 (one HOLD cycle).
REQ-022 IF_ID_Flush SHALL be (BranchTaken or ID_Jump) and not stall; while stalled a redirect SHALL be suppressed, since the branch is not yet resolved.
REQ-023 Total stall for one 2-bubble hazard SHALL be exactly 2 consecutive cycles; total for a 1-bubble hazard SHALL be exactly 1 cycle.
REQ-024 Register 0 as destination SHALL never cause a stall.

Reset
REQ-025 On rst_n low, state SHALL go to RUN, cnt to 0 and StallCount to 0 immediately, regardless of clk.
REQ-026 With idle inputs during reset: PCWrite = 1, IF_ID_Write = 1, ID_EX_Flush = 0, IF_ID_Flush = 0.
REQ-027 Reset asserted in HOLD SHALL abort the stall; the first post-reset cycle SHALL evaluate need fresh.

Configuration
REQ-028 Macro HAZARD_PERF_CNT_EN defined: StallCount SHALL increment by 1 on each clk edge where stall = 1, saturating at 32'hFFFFFFFF.
REQ-029 Macro HAZARD_PERF_CNT_EN undefined: StallCount SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-030 Load-use: ID_EX_MemRead=1, ID_EX_WriteReg=5, IF_ID_Rs=5 -> one cycle PCWrite=0, ID_EX_Flush=1, then PCWrite=1.
REQ-031 Branch after load: ID_Branch=1, ID_EX_MemRead=1, ID_EX_WriteReg=8, IF_ID_Rt=8, ID_UsesRt=1, inputs then cleared -> exactly 2 stall cycles (HOLD entered once).
REQ-032 Zero destination: ID_EX_MemRead=1, ID_EX_WriteReg=0, IF_ID_Rs=0 -> no stall.
REQ-033 Redirect during stall: BranchTaken=1 while need=1 -> IF_ID_Flush=0 in the stall cycle, and IF_ID_Flush=1 the next cycle if BranchTaken still 1.
REQ-034 rst_n low mid-HOLD -> RUN asynchronously, PCWrite=1 before the next edge.
REQ-035 With HAZARD_PERF_CNT_EN, three 2-bubble hazards -> StallCount=6; without the macro -> StallCount=0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : ID-stage hazard detection; stalls IF/ID and bubbles ID/EX for
//            load-use and branch-operand hazards. Optional stall counter is
//            enabled with the HAZARD_PERF_CNT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        BranchTaken,
  input  logic        ID_Jump,
  input  logic [4:0]  ID_EX_WriteReg,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic [4:0]  EX_MEM_WriteReg,
  input  logic        EX_MEM_MemRead,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Flush,
  output logic        IF_ID_Flush,
  output logic [31:0] StallCount
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [1:0]  c_cnt_one = 2'd1;
  localparam logic [31:0] c_sat_max = 32'hFFFF_FFFF;

  state_t     r_state;
  logic [1:0] r_cnt;

  logic w_match_ex;
  logic w_match_mem;
  logic w_need_one;
  logic w_need_two;
  logic w_stall;

  // Register 0 is hard-wired, so it never produces a dependency.
  assign w_match_ex  = (ID_EX_WriteReg != 5'd0) &&
                       ((ID_EX_WriteReg == IF_ID_Rs) ||
                        (ID_UsesRt && (ID_EX_WriteReg == IF_ID_Rt)));
  assign w_match_mem = (EX_MEM_WriteReg != 5'd0) &&
                       ((EX_MEM_WriteReg == IF_ID_Rs) ||
                        (ID_UsesRt && (EX_MEM_WriteReg == IF_ID_Rt)));

  assign w_need_two = ID_Branch && ID_EX_MemRead && w_match_ex;
  assign w_need_one = (ID_EX_MemRead && w_match_ex) ||
                      (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && w_match_ex) ||
                      (ID_Branch && EX_MEM_MemRead && w_match_mem);

  assign w_stall = (r_state == HOLD) || w_need_one || w_need_two;

  assign PCWrite     = !w_stall;
  assign IF_ID_Write = !w_stall;
  assign ID_EX_Flush = w_stall;
  // A redirect seen while stalled is based on an unresolved compare.
  assign IF_ID_Flush = (BranchTaken || ID_Jump) && !w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_need_two) begin
            r_cnt   <= c_cnt_one;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt <= c_cnt_one) begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 32'd0;
    end else if (w_stall && (r_stall_count != c_sat_max)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign StallCount = r_stall_count;
`else
  assign StallCount = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Directed and randomized checks of hazard_stall_unit against a
//            bubble-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_Rs, IF_ID_Rt;
  logic        ID_UsesRt, ID_Branch, BranchTaken, ID_Jump;
  logic [4:0]  ID_EX_WriteReg;
  logic        ID_EX_RegWrite, ID_EX_MemRead;
  logic [4:0]  EX_MEM_WriteReg;
  logic        EX_MEM_MemRead;
  logic        PCWrite, IF_ID_Write, ID_EX_Flush, IF_ID_Flush;
  logic [31:0] StallCount;

  hazard_stall_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Branch      (ID_Branch),
    .BranchTaken    (BranchTaken),
    .ID_Jump        (ID_Jump),
    .ID_EX_WriteReg (ID_EX_WriteReg),
    .ID_EX_RegWrite (ID_EX_RegWrite),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .EX_MEM_WriteReg(EX_MEM_WriteReg),
    .EX_MEM_MemRead (EX_MEM_MemRead),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .ID_EX_Flush    (ID_EX_Flush),
    .IF_ID_Flush    (IF_ID_Flush),
    .StallCount     (StallCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: extra bubbles still owed, and the expected counter.
  int          bubbles_owed;
  logic [31:0] exp_sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((r == IF_ID_Rs) || (ID_UsesRt && (r == IF_ID_Rt)));
  endfunction

  function automatic int need_now();
    int n = 0;
    if (ID_EX_MemRead && reads(ID_EX_WriteReg) && n < 1) n = 1;
    if (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && reads(ID_EX_WriteReg) && n < 1) n = 1;
    if (ID_Branch && ID_EX_MemRead && reads(ID_EX_WriteReg)) n = 2;
    if (ID_Branch && EX_MEM_MemRead && reads(EX_MEM_WriteReg) && n < 1) n = 1;
    return n;
  endfunction

  function automatic bit model_stall();
    return (bubbles_owed > 0) || (need_now() > 0);
  endfunction

  task automatic check_outputs(input string ctx);
    bit s;
    s = model_stall();
    chk({ctx, ".PCWrite"},     {31'd0, PCWrite},     {31'd0, !s});
    chk({ctx, ".IF_ID_Write"}, {31'd0, IF_ID_Write}, {31'd0, !s});
    chk({ctx, ".ID_EX_Flush"}, {31'd0, ID_EX_Flush}, {31'd0, s});
    chk({ctx, ".IF_ID_Flush"}, {31'd0, IF_ID_Flush}, {31'd0, (BranchTaken || ID_Jump) && !s});
`ifdef HAZARD_PERF_CNT_EN
    chk({ctx, ".StallCount"},  StallCount, exp_sc);
`else
    chk({ctx, ".StallCount"},  StallCount, 32'd0);
`endif
  endtask

  // Advance one clock and update the model; returns at posedge + 1.
  task automatic tick();
    bit s;
    int n;
    s = model_stall();
    n = need_now();
    @(posedge clk);
    if (bubbles_owed > 0)  bubbles_owed--;
    else if (n == 2)       bubbles_owed = 1;
    if (s && exp_sc != 32'hFFFF_FFFF) exp_sc++;
    #1;
  endtask

  task automatic idle_inputs();
    IF_ID_Rs = 0; IF_ID_Rt = 0; ID_UsesRt = 0; ID_Branch = 0;
    BranchTaken = 0; ID_Jump = 0; ID_EX_WriteReg = 0; ID_EX_RegWrite = 0;
    ID_EX_MemRead = 0; EX_MEM_WriteReg = 0; EX_MEM_MemRead = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bubbles_owed = 0;
    exp_sc = 32'd0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic branch_after_load(input string tag);
    ID_Branch = 1; ID_EX_MemRead = 1; ID_EX_WriteReg = 8; IF_ID_Rt = 8; ID_UsesRt = 1;
    #1 check_outputs({tag, "_c1"});
    chk({tag, "_c1_stall"}, {31'd0, PCWrite}, 32'd0);
    tick();
    idle_inputs();
    #1 check_outputs({tag, "_c2"});
    chk({tag, "_c2_stall"}, {31'd0, PCWrite}, 32'd0);
    tick();
    #1 check_outputs({tag, "_c3"});
    chk({tag, "_c3_run"}, {31'd0, PCWrite}, 32'd1);
    tick();
  endtask

  initial begin
    idle_inputs();
    apply_reset();
    chk("reset_pcwrite", {31'd0, PCWrite}, 32'd1);

    // Load-use: one bubble.
    ID_EX_MemRead = 1; ID_EX_WriteReg = 5; IF_ID_Rs = 5;
    #1 check_outputs("lu_c1");
    chk("lu_c1_pcwrite", {31'd0, PCWrite}, 32'd0);
    tick();
    idle_inputs();
    #1 check_outputs("lu_c2");
    chk("lu_c2_pcwrite", {31'd0, PCWrite}, 32'd1);
    tick();

    branch_after_load("bal");

    // Zero destination never stalls.
    ID_EX_MemRead = 1; ID_EX_WriteReg = 0; IF_ID_Rs = 0;
    #1 check_outputs("zero");
    chk("zero_pcwrite", {31'd0, PCWrite}, 32'd1);
    tick();
    idle_inputs();

    // Redirect suppressed during stall, then taken.
    ID_EX_MemRead = 1; ID_EX_WriteReg = 3; IF_ID_Rs = 3; BranchTaken = 1;
    #1 check_outputs("redir_c1");
    chk("redir_c1_flush", {31'd0, IF_ID_Flush}, 32'd0);
    tick();
    ID_EX_MemRead = 0; ID_EX_WriteReg = 0; IF_ID_Rs = 0;
    #1 check_outputs("redir_c2");
    chk("redir_c2_flush", {31'd0, IF_ID_Flush}, 32'd1);
    tick();
    idle_inputs();

    // Three 2-bubble hazards from a fresh counter.
    apply_reset();
    branch_after_load("h1");
    branch_after_load("h2");
    branch_after_load("h3");
`ifdef HAZARD_PERF_CNT_EN
    chk("three_hazards_count", StallCount, 32'd6);
`else
    chk("three_hazards_count", StallCount, 32'd0);
`endif

    // Asynchronous reset in the middle of HOLD.
    ID_Branch = 1; ID_EX_MemRead = 1; ID_EX_WriteReg = 9; IF_ID_Rs = 9;
    tick();
    idle_inputs();
    #1 chk("hold_before_rst", {31'd0, PCWrite}, 32'd0);
    rst_n = 1'b0;
    #1 chk("hold_async_rst_pcwrite", {31'd0, PCWrite}, 32'd1);
    chk("hold_async_rst_count", StallCount, 32'd0);
    bubbles_owed = 0;
    exp_sc = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_outputs("post_rst");
    tick();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      IF_ID_Rs        = 5'($urandom_range(0, 3));
      IF_ID_Rt        = 5'($urandom_range(0, 3));
      ID_UsesRt       = 1'($urandom);
      ID_Branch       = 1'($urandom);
      BranchTaken     = 1'($urandom);
      ID_Jump         = ($urandom_range(0, 7) == 0);
      ID_EX_WriteReg  = 5'($urandom_range(0, 3));
      ID_EX_RegWrite  = 1'($urandom);
      ID_EX_MemRead   = 1'($urandom);
      EX_MEM_WriteReg = 5'($urandom_range(0, 3));
      EX_MEM_MemRead  = 1'($urandom);
      #1 check_outputs("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
